// File: rtl/platform_onchip_mem_pkg.sv
// Shared types, sizing helpers and elaboration-time parameter checks for the
// platform on-chip memory slave.
`ifndef PLATFORM_ONCHIP_MEM_PKG_SV
`define PLATFORM_ONCHIP_MEM_PKG_SV

// Stops elaboration with a message when a parameter combination is illegal.
`define POM_PARAM_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end

package platform_onchip_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  // At least one bit so that a single-word memory still has a counter.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit legal_latency(input int latency);
    return (latency >= LAT_MIN) && (latency <= LAT_MAX);
  endfunction

endpackage

`endif

// File: rtl/platform_onchip_mem_array.sv
// Single-port byte-enabled memory with a synchronous one-cycle read port.
// The read register loads only on a read so it keeps its last value otherwise.
module platform_onchip_mem_array
  import platform_onchip_mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 1024,
  parameter string INIT_FILE  = ""
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              ce,
  input  logic [cnt_width(DEPTH)-1:0]       addr,
  input  logic                              we,
  input  logic [lane_count(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic                              rd_en,
  input  logic                              rd_zero,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int NB = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // read register below is reset.
  always_ff @(posedge clk) begin
    if (ce && we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (ce && rd_en) begin
      rdata <= rd_zero ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/platform_onchip_mem.sv
// Avalon-MM on-chip memory slave: ROM/RAM modes, 1- or 2-cycle read latency,
// range/protection error strobe and a hardware clear engine.
module platform_onchip_mem
  import platform_onchip_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    DEPTH        = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter int                    WRITABLE     = 0,
  parameter string                 INIT_FILE    = "platform_rom.hex",
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [lane_count(DATA_WIDTH)-1:0] byteenable,
  input  logic                              chipselect,
  input  logic                              read,
  input  logic                              write,
  input  logic [DATA_WIDTH-1:0]             writedata,
  input  logic                              debugaccess,
  input  logic                              clken,
  input  logic                              reset_req,
  input  logic                              clear_req,
  output logic [DATA_WIDTH-1:0]             readdata,
  output logic                              readdatavalid,
  output logic                              waitrequest,
  output logic                              clear_busy,
  output logic                              access_err
);

  localparam int              NB           = lane_count(DATA_WIDTH);
  localparam int              CW           = cnt_width(DEPTH);
  localparam bit              FULL_RANGE   = (DEPTH == (1 << ADDR_WIDTH));
  localparam bit              BUS_WRITABLE = (WRITABLE != 0);
  localparam logic [CW-1:0]   LAST_WORD    = CW'(DEPTH - 1);

  `POM_PARAM_CHECK(g_chk_width, (DATA_WIDTH % 8 == 0) && (DATA_WIDTH >= 8) && (DATA_WIDTH <= 128),
                   "platform_onchip_mem: DATA_WIDTH must be a multiple of 8 in 8..128")
  `POM_PARAM_CHECK(g_chk_depth, (DEPTH >= 1) && (DEPTH <= (1 << ADDR_WIDTH)),
                   "platform_onchip_mem: DEPTH must be 1..2**ADDR_WIDTH")
  `POM_PARAM_CHECK(g_chk_lat, legal_latency(READ_LATENCY),
                   "platform_onchip_mem: READ_LATENCY must be 1 or 2")

  clr_state_e    state;
  logic [CW-1:0] clr_cnt;

  logic en;
  logic in_range;
  logic accept;
  logic rd_acc;
  logic wr_acc;
  logic wr_ok;
  logic clearing;

  assign en          = clken & ~reset_req;
  assign waitrequest = ~en | (state != IDLE);
  assign clear_busy  = (state == CLEAR);

  if (FULL_RANGE) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = ({1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH));
  end

  // Simultaneous read and write is handled as a write that also flags an error.
  assign accept = chipselect & (read | write) & ~waitrequest;
  assign wr_acc = accept & write;
  assign rd_acc = accept & read & ~write;
  assign wr_ok  = wr_acc & in_range & (BUS_WRITABLE | debugaccess);

  // Clear engine: one word per enabled cycle, DEPTH cycles in total.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_WORD) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write port belongs to the clear engine while it runs; the bus is
  // stalled by waitrequest then, so the two never compete.
  logic [CW-1:0]         arr_addr;
  logic                  arr_we;
  logic [NB-1:0]         arr_be;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign clearing  = clear_busy & en;
  assign arr_addr  = clear_busy ? clr_cnt : address[CW-1:0];
  assign arr_we    = clearing | wr_ok;
  assign arr_be    = clear_busy ? {NB{1'b1}} : byteenable;
  assign arr_wdata = clear_busy ? CLEAR_VALUE : writedata;

  platform_onchip_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (en),
    .addr    (arr_addr),
    .we      (arr_we),
    .be      (arr_be),
    .wdata   (arr_wdata),
    .rd_en   (rd_acc),
    .rd_zero (~in_range),
    .rdata   (arr_rdata)
  );

  // First pipeline stage, aligned with the array read register.
  logic rd_v1;
  logic rd_e1;
  logic wr_e1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1 <= 1'b0;
      rd_e1 <= 1'b0;
      wr_e1 <= 1'b0;
    end else if (en) begin
      rd_v1 <= rd_acc;
      rd_e1 <= rd_acc & ~in_range;
      wr_e1 <= wr_acc & (~wr_ok | read);
    end
  end

  logic rd_v_out;
  logic rd_e_out;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd_v2;
    logic                  rd_e2;
    logic [DATA_WIDTH-1:0] rdata2;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_v2  <= 1'b0;
        rd_e2  <= 1'b0;
        rdata2 <= '0;
      end else if (en) begin
        rd_v2 <= rd_v1;
        rd_e2 <= rd_e1;
        if (rd_v1) rdata2 <= arr_rdata;
      end
    end

    assign rd_v_out = rd_v2;
    assign rd_e_out = rd_e2;
    assign readdata = rdata2;
  end else begin : g_lat1
    assign rd_v_out = rd_v1;
    assign rd_e_out = rd_e1;
    assign readdata = arr_rdata;
  end

  // Strobes are masked while frozen; the held stage shows again on release.
  assign readdatavalid = en & rd_v_out;
  assign access_err    = en & (rd_e_out | wr_e1);

endmodule
